key_sequencer: RTL

KEY_SEQUENCER -- requirements
Module: key_sequencer

---
 rtl/key_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/key_sequencer.sv
// Key-to-strobe sequencer: one strobe per key press, evaluation handshake with timeout.
// Define KEYSEQ_DEBOUNCE_EN to require RELEASE_CYCLES quiet cycles before re-arming.
module key_sequencer #(
  parameter int unsigned BUTTONS        = 26,
  parameter int unsigned CODEW          = 5,
  parameter int unsigned EVAL_TIMEOUT   = 1023,
  parameter int unsigned RELEASE_CYCLES = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [BUTTONS-1:0] b,
  input  logic               del,
  input  logic               ptrLeft,
  input  logic               ptrRight,
  input  logic               eval,
  input  logic               done,
  output logic               tokenValid,
  output logic [CODEW-1:0]   tokenCode,
  output logic               delPulse,
  output logic               leftPulse,
  output logic               rightPulse,
  output logic               evalStart,
  output logic               busy,
  output logic               timeout
);

  localparam int unsigned CntW = $clog2(EVAL_TIMEOUT + 1);

  if (CODEW < $clog2(BUTTONS) || EVAL_TIMEOUT == 0 || RELEASE_CYCLES == 0) begin : g_param_check
    $error("key_sequencer: illegal parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StHold, StEvalRun} state_e;
  typedef enum logic [2:0] {KeyNone, KeyTok, KeyDel, KeyLeft, KeyRight, KeyEval} key_e;

  state_e             state_q;
  key_e               kind_q, win_kind;
  logic [CODEW-1:0]   code_q, win_code;
  logic [CntW-1:0]    cnt_q;
  logic [BUTTONS-1:0] b_q;
  logic               del_q, left_q, right_q, eval_q, done_q;
  logic               sampled_q;
  logic               any_key, hold_busy;

`ifdef KEYSEQ_DEBOUNCE_EN
  localparam int unsigned RelW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  logic [RelW-1:0] rel_q;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b_q       <= '0;
      del_q     <= 1'b0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      eval_q    <= 1'b0;
      done_q    <= 1'b0;
      sampled_q <= 1'b0;
    end else begin
      b_q       <= b;
      del_q     <= del;
      left_q    <= ptrLeft;
      right_q   <= ptrRight;
      eval_q    <= eval;
      done_q    <= done;
      sampled_q <= 1'b1;
    end
  end

  assign any_key = (|b_q) | del_q | left_q | right_q | eval_q;
  // The zeroed input registers right after reset are not a real sample of the keys.
  assign hold_busy = any_key | ~sampled_q;

  always_comb begin
    win_kind = KeyNone;
    win_code = '0;
    for (int i = 0; i < BUTTONS; i++) begin
      if (b_q[i] && win_kind == KeyNone) begin
        win_kind = KeyTok;
        win_code = CODEW'(i);
      end
    end
    if (right_q) begin win_kind = KeyRight; win_code = '0; end
    if (left_q)  begin win_kind = KeyLeft;  win_code = '0; end
    if (del_q)   begin win_kind = KeyDel;   win_code = '0; end
    if (eval_q)  begin win_kind = KeyEval;  win_code = '0; end
  end

  // Reset lands in HOLD so a key held through reset must be released before it can issue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StHold;
      kind_q     <= KeyNone;
      code_q     <= '0;
      cnt_q      <= '0;
      tokenValid <= 1'b0;
      tokenCode  <= '0;
      delPulse   <= 1'b0;
      leftPulse  <= 1'b0;
      rightPulse <= 1'b0;
      evalStart  <= 1'b0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
`ifdef KEYSEQ_DEBOUNCE_EN
      rel_q      <= '0;
`endif
    end else begin
      tokenValid <= 1'b0;
      tokenCode  <= '0;
      delPulse   <= 1'b0;
      leftPulse  <= 1'b0;
      rightPulse <= 1'b0;
      evalStart  <= 1'b0;
      timeout    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_key) begin
            state_q <= StIssue;
            kind_q  <= win_kind;
            code_q  <= win_code;
          end
        end
        StIssue: begin
          unique case (kind_q)
            KeyTok:   begin tokenValid <= 1'b1; tokenCode <= code_q; end
            KeyDel:   delPulse   <= 1'b1;
            KeyLeft:  leftPulse  <= 1'b1;
            KeyRight: rightPulse <= 1'b1;
            KeyEval:  begin evalStart <= 1'b1; busy <= 1'b1; cnt_q <= '0; end
            default:  ;
          endcase
          state_q <= (kind_q == KeyEval) ? StEvalRun : StHold;
        end
        StHold: begin
`ifdef KEYSEQ_DEBOUNCE_EN
          if (hold_busy) begin
            rel_q <= '0;
          end else if (rel_q == RelW'(RELEASE_CYCLES - 1)) begin
            rel_q   <= '0;
            state_q <= StIdle;
          end else begin
            rel_q <= rel_q + 1'b1;
          end
`else
          if (!hold_busy) state_q <= StIdle;
`endif
        end
        StEvalRun: begin
          if (done_q) begin
            busy    <= 1'b0;
            state_q <= StHold;
          end else if (cnt_q == CntW'(EVAL_TIMEOUT - 1)) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state_q <= StHold;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StHold;
      endcase
    end
  end

endmodule
